adv_timer_ext_sig_filter: RTL



---
 rtl/adv_timer_ext_filt_pkg.sv | 21 ++
 rtl/adv_timer_ext_filt_ch.sv | 125 ++++++++++++
 rtl/adv_timer_ext_sig_filter.sv | 36 +++
 3 files changed

// File: rtl/adv_timer_ext_filt_pkg.sv
// Shared types and defaults for the external-signal glitch filter that feeds
// the advanced timer's ext_sig_i inputs.
package adv_timer_ext_filt_pkg;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_QUAL_HI,
        ST_HIGH,
        ST_QUAL_LO
    } ext_filt_state_t;

    localparam int EXT_FILT_DEF_N_CH  = 32;
    localparam int EXT_FILT_DEF_CNT_W = 8;
    localparam int EXT_FILT_DEF_SYNC  = 2;

    // Filtered level presented while in a given state.
    function automatic logic state_level(input ext_filt_state_t st);
        return (st == ST_HIGH) || (st == ST_QUAL_LO);
    endfunction

endpackage

// File: rtl/adv_timer_ext_filt_ch.sv
// One filter channel: synchroniser, qualification FSM with saturating
// counter, and registered rise/fall pulses.
module adv_timer_ext_filt_ch
    import adv_timer_ext_filt_pkg::*;
#(
    parameter int SYNC_STAGES = EXT_FILT_DEF_SYNC,
    parameter int CNT_W       = EXT_FILT_DEF_CNT_W
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             ext_sig_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] filt_len_i,
    output logic             ext_sig_o,
    output logic             rise_o,
    output logic             fall_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    ext_filt_state_t        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_sig_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // NOTE: defaults at the top of the block keep every path assigned, so no
    // latches are inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en_i) begin
            state_d = ST_LOW;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_LOW: begin
                    if (s) begin
                        if (filt_len_i == '0) begin
                            state_d = ST_HIGH;
                        end else begin
                            state_d = ST_QUAL_HI;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_QUAL_HI: begin
                    if (!s) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q >= filt_len_i) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        if (filt_len_i == '0) begin
                            state_d = ST_LOW;
                        end else begin
                            state_d = ST_QUAL_LO;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_QUAL_LO: begin
                    if (s) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q >= filt_len_i) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pulses are suppressed when disabled so the forced drop to ST_LOW is silent.
    always_comb begin
        ext_sig_o = state_level(state_q);
        rise_d    = en_i && !state_level(state_q) &&  state_level(state_d);
        fall_d    = en_i &&  state_level(state_q) && !state_level(state_d);
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/adv_timer_ext_sig_filter.sv
// Bank of external-signal filters in front of apb_adv_timer ext_sig_i; all
// channels share one filter length.
module adv_timer_ext_sig_filter
    import adv_timer_ext_filt_pkg::*;
#(
    parameter int N_CH        = EXT_FILT_DEF_N_CH,
    parameter int SYNC_STAGES = EXT_FILT_DEF_SYNC,
    parameter int CNT_W       = EXT_FILT_DEF_CNT_W
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [N_CH-1:0]  ext_sig_i,
    input  logic [N_CH-1:0]  en_i,
    input  logic [CNT_W-1:0] filt_len_i,
    output logic [N_CH-1:0]  ext_sig_o,
    output logic [N_CH-1:0]  rise_o,
    output logic [N_CH-1:0]  fall_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        adv_timer_ext_filt_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .HCLK       (HCLK),
            .HRESET     (HRESET),
            .ext_sig_i  (ext_sig_i[i]),
            .en_i       (en_i[i]),
            .filt_len_i (filt_len_i),
            .ext_sig_o  (ext_sig_o[i]),
            .rise_o     (rise_o[i]),
            .fall_o     (fall_o[i])
        );
    end

endmodule
